// File: rtl/execute_md_if.sv
// Decode-to-execute bundle for execute_md: control, register indices, immediates and operand data.
interface execute_md_if #(
  parameter int XLEN = 32
);
  logic            pc_write_d;
  logic            rd_write_d;
  logic            mem_write_d;
  logic [1:0]      rd_write_src_d;
  logic [3:0]      alu_op_d;
  logic            src_a_sel_d;
  logic [1:0]      src_b_sel_d;
  logic            md_valid_d;
  logic [2:0]      md_op_d;
  logic [4:0]      rd_d;
  logic [4:0]      rs1_d;
  logic [4:0]      rs2_d;
  logic [XLEN-1:0] immI_d;
  logic [XLEN-1:0] immS_d;
  logic [XLEN-1:0] immU_d;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] rs1_data_d;
  logic [XLEN-1:0] rs2_data_d;

  modport master (
    output pc_write_d, rd_write_d, mem_write_d, rd_write_src_d, alu_op_d,
           src_a_sel_d, src_b_sel_d, md_valid_d, md_op_d, rd_d, rs1_d, rs2_d,
           immI_d, immS_d, immU_d, pc_d, rs1_data_d, rs2_data_d
  );

  modport slave (
    input  pc_write_d, rd_write_d, mem_write_d, rd_write_src_d, alu_op_d,
           src_a_sel_d, src_b_sel_d, md_valid_d, md_op_d, rd_d, rs1_d, rs2_d,
           immI_d, immS_d, immU_d, pc_d, rs1_data_d, rs2_data_d
  );
endinterface

// File: rtl/execute_md.sv
// RISC-V execute stage: D->E register, operand forwarding, ALU and an iterative RV32M/RV64M unit.
// The multiply/divide unit is compiled in only when EXECUTE_MD_EN is defined.
module execute_md #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  execute_md_if.slave     dec,
  input  logic [XLEN-1:0] alu_res_m,
  input  logic [XLEN-1:0] rd_data_w,
  input  logic            stall_e,
  input  logic            flush_e,
  input  logic [1:0]      fwd_rs1_e,
  input  logic [1:0]      fwd_rs2_e,
  output logic            pc_write_e,
  output logic            rd_write_e,
  output logic            mem_write_e,
  output logic [1:0]      rd_write_src_e,
  output logic [4:0]      rd_e,
  output logic [4:0]      rs1_e,
  output logic [4:0]      rs2_e,
  output logic [XLEN-1:0] pc_e,
  output logic [XLEN-1:0] alu_res_e,
  output logic [XLEN-1:0] mem_data_e,
  output logic            busy_e
);

  localparam int SHW = $clog2(XLEN);

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
  } alu_op_e;

  typedef struct packed {
    logic            pc_write;
    logic            rd_write;
    logic            mem_write;
    logic [1:0]      rd_write_src;
    logic [3:0]      alu_op;
    logic            src_a_sel;
    logic [1:0]      src_b_sel;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
  } e_reg_t;

  e_reg_t          e_d, e_q;
  logic [XLEN-1:0] rs1_val, rs2_val, src_a, src_b, alu_res;

  always_comb begin
    e_d = '{
      pc_write:     dec.pc_write_d,
      rd_write:     dec.rd_write_d,
      mem_write:    dec.mem_write_d,
      rd_write_src: dec.rd_write_src_d,
      alu_op:       dec.alu_op_d,
      src_a_sel:    dec.src_a_sel_d,
      src_b_sel:    dec.src_b_sel_d,
      rd:           dec.rd_d,
      rs1:          dec.rs1_d,
      rs2:          dec.rs2_d,
      imm_i:        dec.immI_d,
      imm_s:        dec.immS_d,
      imm_u:        dec.immU_d,
      pc:           dec.pc_d,
      rs1_data:     dec.rs1_data_d,
      rs2_data:     dec.rs2_data_d
    };
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || flush_e) begin
      e_q <= '0;
    end else if (!stall_e && !busy_e) begin
      e_q <= e_d;
    end
  end

  // Forwarding: 01 = writeback, 10 = memory, 00/11 = register file value.
  always_comb begin
    rs1_val = e_q.rs1_data;
    rs2_val = e_q.rs2_data;
    if (fwd_rs1_e == 2'b01) rs1_val = rd_data_w;
    else if (fwd_rs1_e == 2'b10) rs1_val = alu_res_m;
    if (fwd_rs2_e == 2'b01) rs2_val = rd_data_w;
    else if (fwd_rs2_e == 2'b10) rs2_val = alu_res_m;
  end

  always_comb begin
    src_a = e_q.src_a_sel ? e_q.pc : rs1_val;
    case (e_q.src_b_sel)
      2'b01:   src_b = e_q.imm_i;
      2'b10:   src_b = e_q.imm_s;
      2'b11:   src_b = e_q.imm_u;
      default: src_b = rs2_val;
    endcase
  end

  // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
  always_comb begin
    alu_res = '0;
    case (e_q.alu_op)
      ALU_ADD:   alu_res = src_a + src_b;
      ALU_SUB:   alu_res = src_a - src_b;
      ALU_SLL:   alu_res = src_a << src_b[SHW-1:0];
      ALU_SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      ALU_SLTU:  alu_res = {{(XLEN-1){1'b0}}, src_a < src_b};
      ALU_XOR:   alu_res = src_a ^ src_b;
      ALU_SRL:   alu_res = src_a >> src_b[SHW-1:0];
      ALU_SRA:   alu_res = $signed(src_a) >>> src_b[SHW-1:0];
      ALU_OR:    alu_res = src_a | src_b;
      ALU_AND:   alu_res = src_a & src_b;
      ALU_PASSB: alu_res = src_b;
      default:   alu_res = '0;
    endcase
  end

`ifdef EXECUTE_MD_EN
  typedef enum logic [1:0] {MD_IDLE, MD_CALC, MD_DONE} md_state_e;
  typedef enum logic [2:0] {
    MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU
  } md_op_e;

  md_state_e         state_q;
  logic              md_valid_q;
  logic [2:0]        md_op_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2*XLEN-1:0] acc_q, acc_step, prod_s;
  logic [XLEN-1:0]   opnd_q, md_res_q, md_res_d, mag_a, mag_b, quo_s, rem_s;
  logic [XLEN:0]     shifted, diff, sum;
  logic              neg_quo_q, neg_rem_q, is_div, sign_a, sign_b;

  always_ff @(posedge clk) begin
    if (rst || flush_e) begin
      md_valid_q <= 1'b0;
      md_op_q    <= '0;
    end else if (!stall_e && !busy_e) begin
      md_valid_q <= dec.md_valid_d;
      md_op_q    <= dec.md_op_d;
    end
  end

  always_comb begin
    is_div = md_op_q[2];
    sign_a = rs1_val[XLEN-1] &&
             (is_div ? !md_op_q[0] : (md_op_q == MD_MULH || md_op_q == MD_MULHSU));
    sign_b = rs2_val[XLEN-1] && (is_div ? !md_op_q[0] : (md_op_q == MD_MULH));
    mag_a  = sign_a ? -rs1_val : rs1_val;
    mag_b  = sign_b ? -rs2_val : rs2_val;

    // Divide: restoring step on {remainder, dividend}; multiply: shift-add on {acc, multiplier}.
    shifted  = acc_q[2*XLEN-1:XLEN-1];
    diff     = shifted - {1'b0, opnd_q};
    sum      = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    acc_step = {sum, acc_q[XLEN-1:1]};
    if (is_div) begin
      acc_step = diff[XLEN] ? {shifted[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                            : {diff[XLEN-1:0],    acc_q[XLEN-2:0], 1'b1};
    end

    prod_s = neg_quo_q ? -acc_step : acc_step;
    quo_s  = neg_quo_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
    rem_s  = neg_rem_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
    case (md_op_q)
      MD_MUL:                       md_res_d = prod_s[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: md_res_d = prod_s[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              md_res_d = quo_s;
      default:                      md_res_d = rem_s;
    endcase
  end

  // NOTE: datapath registers carry no reset; IDLE always loads them before CALC reads them.
  always_ff @(posedge clk) begin
    if (rst || flush_e) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (md_valid_q) begin
            state_q   <= MD_CALC;
            cnt_q     <= '0;
            opnd_q    <= is_div ? mag_b : mag_a;
            acc_q     <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
            // A zero divisor keeps the all-ones quotient unsigned-looking.
            neg_quo_q <= (sign_a ^ sign_b) && (rs2_val != '0);
            neg_rem_q <= sign_a;
          end
        end
        MD_CALC: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(XLEN-1)) begin
            md_res_q <= md_res_d;
            state_q  <= MD_DONE;
          end
        end
        MD_DONE: state_q <= MD_IDLE;
        default: state_q <= MD_IDLE;
      endcase
    end
  end

  assign busy_e    = md_valid_q && (state_q != MD_DONE);
  assign alu_res_e = md_valid_q ? md_res_q : alu_res;
`else
  logic unused_md;
  assign unused_md = ^{dec.md_valid_d, dec.md_op_d} ^ (CNT_W == 0);
  assign busy_e    = 1'b0;
  assign alu_res_e = alu_res;
`endif

  // A stalled multi-cycle op must look like a bubble to the memory stage.
  assign pc_write_e     = e_q.pc_write  && !busy_e;
  assign rd_write_e     = e_q.rd_write  && !busy_e;
  assign mem_write_e    = e_q.mem_write && !busy_e;
  assign rd_write_src_e = e_q.rd_write_src;
  assign rd_e           = e_q.rd;
  assign rs1_e          = e_q.rs1;
  assign rs2_e          = e_q.rs2;
  assign pc_e           = e_q.pc;
  assign mem_data_e     = rs2_val;

endmodule

// File: tb/tb_execute_md.sv
// Directed bench for execute_md; MD-unit checks are selected by EXECUTE_MD_EN to match the RTL build.
module tb_execute_md;

  localparam int XLEN = 32;

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_SLL = 4'd2, OP_SLT = 4'd3,
                         OP_SLTU = 4'd4, OP_XOR = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7,
                         OP_OR = 4'd8, OP_AND = 4'd9, OP_PASSB = 4'd10;

  logic            clk = 1'b0;
  logic            rst;
  logic [XLEN-1:0] alu_res_m, rd_data_w;
  logic            stall_e, flush_e;
  logic [1:0]      fwd_rs1_e, fwd_rs2_e;
  logic            pc_write_e, rd_write_e, mem_write_e, busy_e;
  logic [1:0]      rd_write_src_e;
  logic [4:0]      rd_e, rs1_e, rs2_e;
  logic [XLEN-1:0] pc_e, alu_res_e, mem_data_e;

  int checks = 0;
  int errors = 0;

  execute_md_if #(.XLEN(XLEN)) dec_bus ();

  execute_md #(.XLEN(XLEN)) dut (
    .clk            (clk),
    .rst            (rst),
    .dec            (dec_bus),
    .alu_res_m      (alu_res_m),
    .rd_data_w      (rd_data_w),
    .stall_e        (stall_e),
    .flush_e        (flush_e),
    .fwd_rs1_e      (fwd_rs1_e),
    .fwd_rs2_e      (fwd_rs2_e),
    .pc_write_e     (pc_write_e),
    .rd_write_e     (rd_write_e),
    .mem_write_e    (mem_write_e),
    .rd_write_src_e (rd_write_src_e),
    .rd_e           (rd_e),
    .rs1_e          (rs1_e),
    .rs2_e          (rs2_e),
    .pc_e           (pc_e),
    .alu_res_e      (alu_res_e),
    .mem_data_e     (mem_data_e),
    .busy_e         (busy_e)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dec_nop();
    dec_bus.pc_write_d     = 1'b0;
    dec_bus.rd_write_d     = 1'b0;
    dec_bus.mem_write_d    = 1'b0;
    dec_bus.rd_write_src_d = 2'b00;
    dec_bus.alu_op_d       = OP_ADD;
    dec_bus.src_a_sel_d    = 1'b0;
    dec_bus.src_b_sel_d    = 2'b00;
    dec_bus.md_valid_d     = 1'b0;
    dec_bus.md_op_d        = 3'd0;
    dec_bus.rd_d           = 5'd0;
    dec_bus.rs1_d          = 5'd0;
    dec_bus.rs2_d          = 5'd0;
    dec_bus.immI_d         = '0;
    dec_bus.immS_d         = '0;
    dec_bus.immU_d         = '0;
    dec_bus.pc_d           = '0;
    dec_bus.rs1_data_d     = '0;
    dec_bus.rs2_data_d     = '0;
  endtask

  // Operand b goes only into the selected source; the other sources carry decoys.
  task automatic alu_case(input string tag, input logic [3:0] op, input logic [1:0] bsel,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    dec_nop();
    dec_bus.alu_op_d    = op;
    dec_bus.src_b_sel_d = bsel;
    dec_bus.rs1_data_d  = a;
    dec_bus.rs2_data_d  = 32'h1111_1111;
    dec_bus.immI_d      = 32'h2222_2222;
    dec_bus.immS_d      = 32'h3333_3333;
    dec_bus.immU_d      = 32'h4444_4444;
    case (bsel)
      2'b00:   dec_bus.rs2_data_d = b;
      2'b01:   dec_bus.immI_d     = b;
      2'b10:   dec_bus.immS_d     = b;
      default: dec_bus.immU_d     = b;
    endcase
    tick();
    check(tag, alu_res_e, exp);
  endtask

`ifdef EXECUTE_MD_EN
  // rs1 arrives via memory-stage forwarding in cycle 1 and is scrambled afterwards.
  task automatic run_md(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int busy_cnt = 0;
    bit early_wr = 1'b0;
    dec_nop();
    dec_bus.md_valid_d = 1'b1;
    dec_bus.md_op_d    = op;
    dec_bus.rd_write_d = 1'b1;
    dec_bus.rd_d       = 5'd7;
    dec_bus.rs1_data_d = ~a;
    dec_bus.rs2_data_d = b;
    fwd_rs1_e = 2'b10;
    alu_res_m = a;
    tick();
    dec_nop();
    for (int c = 0; c < 100 && busy_e; c++) begin
      busy_cnt++;
      if (rd_write_e) early_wr = 1'b1;
      tick();
      if (c == 0) alu_res_m = 32'hDEAD_BEEF;
    end
    check({tag, " busy cycles"}, busy_cnt, XLEN + 1);
    check({tag, " no write while busy"}, early_wr, 1'b0);
    check({tag, " result"}, alu_res_e, exp);
    check({tag, " write in done"}, rd_write_e, 1'b1);
    fwd_rs1_e = 2'b00;
    alu_res_m = '0;
    tick();
    check({tag, " bubble after"}, rd_write_e, 1'b0);
  endtask

  task automatic start_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    dec_nop();
    dec_bus.md_valid_d = 1'b1;
    dec_bus.md_op_d    = op;
    dec_bus.rd_write_d = 1'b1;
    dec_bus.rd_d       = 5'd9;
    dec_bus.pc_d       = 32'h0000_0200;
    dec_bus.rs1_data_d = a;
    dec_bus.rs2_data_d = b;
    tick();
    dec_nop();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " busy_e"}, busy_e, 1'b0);
    check({tag, " rd_write_e"}, rd_write_e, 1'b0);
    check({tag, " rd_e"}, rd_e, 5'd0);
    check({tag, " pc_e"}, pc_e, 32'd0);
    check({tag, " alu_res_e"}, alu_res_e, 32'd0);
    check({tag, " mem_data_e"}, mem_data_e, 32'd0);
  endtask
`endif

  initial begin
    rst       = 1'b1;
    stall_e   = 1'b0;
    flush_e   = 1'b0;
    fwd_rs1_e = 2'b00;
    fwd_rs2_e = 2'b00;
    alu_res_m = '0;
    rd_data_w = '0;
    dec_nop();
    dec_bus.rd_write_d  = 1'b1;
    dec_bus.mem_write_d = 1'b1;
    dec_bus.rd_d        = 5'd5;
    dec_bus.pc_d        = 32'h0000_0100;
    dec_bus.rs1_data_d  = 32'h0000_0044;
    dec_bus.rs2_data_d  = 32'h0000_0055;
    dec_bus.md_valid_d  = 1'b1;

    // Reset holds everything at zero even with live decode inputs.
    tick();
    tick();
    check("reset rd_write_e", rd_write_e, 1'b0);
    check("reset mem_write_e", mem_write_e, 1'b0);
    check("reset rd_e", rd_e, 5'd0);
    check("reset pc_e", pc_e, 32'd0);
    check("reset alu_res_e", alu_res_e, 32'd0);
    check("reset mem_data_e", mem_data_e, 32'd0);
    check("reset busy_e", busy_e, 1'b0);
    rst = 1'b0;

    // ADD with rs1 forwarded from memory, plus pass-through of control fields.
    dec_nop();
    dec_bus.alu_op_d       = OP_ADD;
    dec_bus.rd_write_d     = 1'b1;
    dec_bus.mem_write_d    = 1'b1;
    dec_bus.pc_write_d     = 1'b1;
    dec_bus.rd_write_src_d = 2'b10;
    dec_bus.rd_d           = 5'd5;
    dec_bus.rs1_d          = 5'd3;
    dec_bus.rs2_d          = 5'd4;
    dec_bus.pc_d           = 32'h0000_0040;
    dec_bus.rs1_data_d     = 32'h0000_0099;
    dec_bus.rs2_data_d     = 32'h0000_0003;
    fwd_rs1_e = 2'b10;
    alu_res_m = 32'h0000_0012;
    rd_data_w = 32'h0000_CAFE;
    tick();
    check("fwd mem add", alu_res_e, 32'h0000_0015);
    check("mem_data reg", mem_data_e, 32'h0000_0003);
    check("rd_write_e", rd_write_e, 1'b1);
    check("mem_write_e", mem_write_e, 1'b1);
    check("pc_write_e", pc_write_e, 1'b1);
    check("rd_write_src_e", rd_write_src_e, 2'b10);
    check("rd_e", rd_e, 5'd5);
    check("rs1_e", rs1_e, 5'd3);
    check("rs2_e", rs2_e, 5'd4);
    check("pc_e", pc_e, 32'h0000_0040);
    fwd_rs2_e = 2'b01;
    #1;
    check("fwd wb mem_data", mem_data_e, 32'h0000_CAFE);
    fwd_rs1_e = 2'b11;
    fwd_rs2_e = 2'b00;
    #1;
    check("fwd 11 uses reg", alu_res_e, 32'h0000_009C);
    fwd_rs1_e = 2'b00;

    // Stall holds the E register, release loads the new instruction, flush clears it.
    dec_bus.rd_d = 5'd9;
    stall_e = 1'b1;
    tick();
    check("stall holds rd_e", rd_e, 5'd5);
    stall_e = 1'b0;
    tick();
    check("unstall loads rd_e", rd_e, 5'd9);
    flush_e = 1'b1;
    tick();
    flush_e = 1'b0;
    check("flush rd_e", rd_e, 5'd0);
    check("flush rd_write_e", rd_write_e, 1'b0);
    check("flush pc_e", pc_e, 32'd0);

    alu_case("sub immI", OP_SUB, 2'b01, 32'h0000_0010, 32'h0000_0005, 32'h0000_000B);
    alu_case("sll rs2", OP_SLL, 2'b00, 32'h0000_0001, 32'h0000_0024, 32'h0000_0010);
    alu_case("srl immS", OP_SRL, 2'b10, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000);
    alu_case("sra immI", OP_SRA, 2'b01, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000);
    alu_case("slt", OP_SLT, 2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001);
    alu_case("sltu", OP_SLTU, 2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
    alu_case("xor", OP_XOR, 2'b00, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0);
    alu_case("or immU", OP_OR, 2'b11, 32'h0000_000F, 32'h1234_5000, 32'h1234_500F);
    alu_case("and", OP_AND, 2'b00, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00);
    alu_case("passb immU", OP_PASSB, 2'b11, 32'h0000_AAAA, 32'h1234_5000, 32'h1234_5000);

    // pc as operand A plus immS.
    dec_nop();
    dec_bus.src_a_sel_d = 1'b1;
    dec_bus.src_b_sel_d = 2'b10;
    dec_bus.pc_d        = 32'h0000_1000;
    dec_bus.rs1_data_d  = 32'h0000_0777;
    dec_bus.immS_d      = 32'h0000_0020;
    tick();
    check("pc + immS", alu_res_e, 32'h0000_1020);
    dec_nop();
    tick();

`ifdef EXECUTE_MD_EN
    run_md("mul", 3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run_md("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_md("mulh", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    run_md("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_md("div ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_md("rem ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
    run_md("divu by 0", 3'd5, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF);
    run_md("remu by 0", 3'd7, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005);
    run_md("div neg", 3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD);
    run_md("rem neg", 3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF);
    run_md("div neg by 0", 3'd4, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFF);
    run_md("rem neg by 0", 3'd6, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB);

    // Flush in the tenth CALC cycle aborts the op; the next op is unaffected.
    start_md(3'd0, 32'h0000_0007, 32'h0000_0009);
    repeat (10) tick();
    check("busy before flush", busy_e, 1'b1);
    flush_e = 1'b1;
    tick();
    flush_e = 1'b0;
    check_all_zero("after flush");
    run_md("mul after flush", 3'd0, 32'h0000_0006, 32'h0000_0007, 32'h0000_002A);

    // Reset mid-CALC behaves like flush.
    start_md(3'd5, 32'h0000_0064, 32'h0000_0007);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("after rst");
    run_md("divu after rst", 3'd5, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E);
`else
    // Without the MD unit an M-op is a plain single-cycle ALU op.
    begin
      bit busy_seen = 1'b0;
      dec_nop();
      dec_bus.md_valid_d = 1'b1;
      dec_bus.md_op_d    = 3'd0;
      dec_bus.rd_write_d = 1'b1;
      dec_bus.rd_d       = 5'd7;
      dec_bus.rs1_data_d = 32'h0000_0007;
      dec_bus.rs2_data_d = 32'h0000_0003;
      tick();
      if (busy_e) busy_seen = 1'b1;
      check("md off result", alu_res_e, 32'h0000_000A);
      check("md off rd_write_e", rd_write_e, 1'b1);
      check("md off rd_e", rd_e, 5'd7);
      for (int c = 0; c < 5; c++) begin
        tick();
        if (busy_e) busy_seen = 1'b1;
      end
      rst = 1'b1;
      tick();
      if (busy_e) busy_seen = 1'b1;
      rst = 1'b0;
      check("md off rst rd_write_e", rd_write_e, 1'b0);
      check("md off rst alu_res_e", alu_res_e, 32'd0);
      check("md off busy never", busy_seen, 1'b0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
